// File: rtl/mmuart_txq.sv
// Byte queue feeding a UART transmitter: circular buffer plus a two-state
// launcher that hands one byte at a time to the transmitter and waits for tx_done.
module mmuart_txq #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  input  logic                  flush,
  input  logic                  clr_overflow,
  output logic [7:0]            tx_data,
  output logic                  tx_wr,
  input  logic                  tx_done,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  idle
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state, state_next;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  launch, push, drop;

  assign empty = (level == '0);
  assign full  = (level == LEVEL_FULL);
  assign idle  = (state == IDLE) && empty;

  // Fullness is the pre-edge value, so a pop on the same edge cannot rescue a write.
  assign push = wr_en && !flush && !full;
  assign drop = wr_en && !flush && full;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !flush) begin
          launch     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (tx_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (launch) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, launch})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_wr   <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      tx_wr <= launch;
      if (launch) begin
        tx_data <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmuart_txq.sv
// Bench for mmuart_txq: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mmuart_txq;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic                sys_clk = 1'b0;
  logic                sys_rst = 1'b1;
  logic [7:0]          wr_data = 8'h00;
  logic                wr_en = 1'b0;
  logic                flush = 1'b0;
  logic                clr_overflow = 1'b0;
  logic                tx_done = 1'b0;
  logic [7:0]          tx_data;
  logic                tx_wr;
  logic [DEPTH_LOG2:0] level;
  logic                empty, full, overflow, idle;

  mmuart_txq #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .flush        (flush),
    .clr_overflow (clr_overflow),
    .tx_data      (tx_data),
    .tx_wr        (tx_wr),
    .tx_done      (tx_done),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .idle         (idle)
  );

  always #5 sys_clk = ~sys_clk;

  int   checks = 0;
  int   passes = 0;
  bit   chk_en = 1'b0;
  int   tx_delay = 20;
  int   tx_cnt = 0;

  logic [7:0] mq[$];
  bit         m_busy = 1'b0;
  bit         m_tx_wr = 1'b0;
  logic [7:0] m_tx_data = 8'h00;
  bit         m_ovf = 1'b0;
  logic [7:0] emitted[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the queue is a plain SV queue, the transmitter handshake a busy bit.
  always @(posedge sys_clk) begin
    bit launch;
    bit full_pre;
    bit dropped;
    if (sys_rst) begin
      mq.delete();
      m_busy = 1'b0;
      m_tx_wr = 1'b0;
      m_tx_data = 8'h00;
      m_ovf = 1'b0;
    end else begin
      full_pre = (mq.size() == DEPTH);
      launch = !m_busy && (mq.size() != 0) && !flush;
      dropped = wr_en && !flush && full_pre;
      m_tx_wr = launch;
      if (launch) m_tx_data = mq.pop_front();
      if (flush) mq.delete();
      else if (wr_en && !full_pre) mq.push_back(wr_data);
      if (dropped) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      if (launch) m_busy = 1'b1;
      else if (m_busy && tx_done) m_busy = 1'b0;
    end
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      checkOutput("level", level, mq.size());
      checkOutput("empty", empty, mq.size() == 0);
      checkOutput("full", full, mq.size() == DEPTH);
      checkOutput("overflow", overflow, m_ovf);
      checkOutput("idle", idle, !m_busy && mq.size() == 0);
      checkOutput("tx_wr", tx_wr, m_tx_wr);
      checkOutput("tx_data", tx_data, m_tx_data);
      if (tx_wr === 1'b1) emitted.push_back(tx_data);
    end
  end

  // Transmitter stand-in: tx_done pulses tx_delay cycles after each tx_wr.
  always @(negedge sys_clk) begin
    tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_done = 1'b1;
    end
    if (tx_wr === 1'b1) tx_cnt = tx_delay;
  end

  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic f,
                               input logic c, input logic r);
    @(negedge sys_clk);
    #1;
    wr_en = w;
    wr_data = d;
    flush = f;
    clr_overflow = c;
    sys_rst = r;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitTxDone(input int budget);
    int k = 0;
    while (tx_done !== 1'b1 && k < budget) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      k++;
    end
    checkOutput("tx_done_within_budget", tx_done, 1);
  endtask

  initial begin
    int base;
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    checkOutput("rst_level", level, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_idle", idle, 1);
    checkOutput("rst_tx_wr", tx_wr, 0);
    checkOutput("rst_tx_data", tx_data, 8'h00);
    checkOutput("rst_overflow", overflow, 0);
    idleCycles(2);

    // Single byte: latency and release back to idle.
    tx_delay = 20;
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("single_level1", level, 1);
    checkOutput("single_no_wr_yet", tx_wr, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("single_tx_wr", tx_wr, 1);
    checkOutput("single_tx_data", tx_data, 8'hA5);
    checkOutput("single_level0", level, 0);
    checkOutput("single_busy", idle, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("single_wr_one_cycle", tx_wr, 0);
    checkOutput("single_data_held", tx_data, 8'hA5);
    waitTxDone(40);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("single_idle_after_done", idle, 1);

    // Burst of 16 bytes emitted in order.
    tx_delay = 4;
    base = emitted.size();
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    idleCycles(140);
    checkOutput("burst_count", emitted.size() - base, 16);
    for (int i = 0; i < 16; i++)
      if (base + i < emitted.size()) checkOutput("burst_order", emitted[base + i], i + 1);
    checkOutput("burst_no_overflow", overflow, 0);

    // Overflow while busy, clear, and clear-versus-drop priority.
    tx_delay = 60;
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    idleCycles(2);
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_level16", level, 16);
    checkOutput("ovf_full", full, 1);
    checkOutput("ovf_set", overflow, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_cleared", overflow, 0);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_set_wins", overflow, 1);
    checkOutput("ovf_level_kept", level, 16);
    tx_delay = 3;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idleCycles(200);
    checkOutput("ovf_drained", empty, 1);

    // Flush with a same-cycle write; in-flight byte still completes.
    tx_delay = 30;
    base = emitted.size();
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    idleCycles(2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_level0", level, 0);
    checkOutput("flush_no_overflow", overflow, 0);
    checkOutput("flush_still_busy", idle, 0);
    waitTxDone(60);
    idleCycles(10);
    checkOutput("flush_one_emitted", emitted.size() - base, 1);
    if (base < emitted.size()) checkOutput("flush_inflight_byte", emitted[base], 8'h55);

    // Write and pop on the same edge across pointer wrap.
    tx_delay = 3;
    base = emitted.size();
    applyStimulus(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 38; i++) begin
      waitTxDone(20);
      applyStimulus(1'b1, 8'(8'h82 + i), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("wrap_level_const", level, 1);
      checkOutput("wrap_launch", tx_wr, 1);
    end
    idleCycles(30);
    checkOutput("wrap_count", emitted.size() - base, 40);
    for (int i = 0; i < 40; i++)
      if (base + i < emitted.size()) checkOutput("wrap_order", emitted[base + i], 8'h80 + i);

    // Reset in the middle of a transfer with queued bytes.
    tx_delay = 30;
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    idleCycles(2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h12 + i), 1'b0, 1'b0, 1'b0);
    base = emitted.size();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_level", level, 0);
    checkOutput("midrst_empty", empty, 1);
    checkOutput("midrst_full", full, 0);
    checkOutput("midrst_idle", idle, 1);
    checkOutput("midrst_tx_wr", tx_wr, 0);
    checkOutput("midrst_tx_data", tx_data, 8'h00);
    checkOutput("midrst_overflow", overflow, 0);
    idleCycles(40);
    checkOutput("midrst_no_late_tx", emitted.size() - base, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tx_delay = $urandom_range(1, 12);
      applyStimulus($urandom_range(0, 99) < 45, 8'($urandom_range(0, 255)),
                    $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
                    $urandom_range(0, 999) < 3);
    end
    idleCycles(300);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
